// File: rtl/irq_hub.sv
// irq_hub: NUM_SRC-way interrupt aggregator with bus-mapped mask, pending, cause and mode registers.
// Optional build macro IRQ_HUB_COUNT_EN adds saturating per-source capture counters at BASE_ADDR+4+i.
module irq_hub #(
   parameter int         NUM_SRC    = 4,
   parameter logic [7:0] BASE_ADDR  = 8'hE0,
   parameter logic [7:0] MASK_RESET = 8'hFF
) (
   input  logic               CLK,
   input  logic               RESET,
   inout  wire  [7:0]         BUS_DATA,
   input  logic [7:0]         BUS_ADDR,
   input  logic               BUS_WE,
   input  logic [NUM_SRC-1:0] SRC_RAISE,
   output logic [NUM_SRC-1:0] SRC_ACK,
   output logic               CPU_IRQ_RAISE,
   input  logic               CPU_IRQ_ACK
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] ack_q, ack_d;
   logic [7:0]         mask_q, mask_d;
   logic [7:0]         cause_q, cause_d;
   logic               mode_q, mode_d;
   logic               irq_q, irq_d;
   logic [2:0]         rr_ptr_q, rr_ptr_d;
   logic [7:0]         rd_data_q, rd_data_d;
   logic [7:0]         out_q, out_d;
   logic               rd_pend_q, rd_pend_d;
   logic               drv_q, drv_d;

   logic [7:0]         offset;
   logic [NUM_SRC-1:0] capture, eligible, wr_clr;
   logic               win_found;
   logic [2:0]         win_idx;
   logic [7:0]         rd_sel;
   logic               rd_hit;

   assign offset   = BUS_ADDR - BASE_ADDR;
   assign capture  = SRC_RAISE & mask_q[NUM_SRC-1:0] & ~pending_q;
   assign eligible = pending_q & mask_q[NUM_SRC-1:0];
   assign wr_clr   = (BUS_WE && offset == 8'd1) ? BUS_DATA[NUM_SRC-1:0] : '0;

`ifdef IRQ_HUB_COUNT_EN
   logic [8*NUM_SRC-1:0] cnt_flat;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
      logic [7:0] cnt_q, cnt_d;

      // A clear coinciding with a capture still records that capture.
      always_comb begin
         cnt_d = cnt_q;
         if (BUS_WE && offset == 8'(4 + gi))
            cnt_d = {7'd0, capture[gi]};
         else if (capture[gi] && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
      end

      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) cnt_q <= 8'h00;
         else       cnt_q <= cnt_d;
      end

      assign cnt_flat[8*gi +: 8] = cnt_q;
   end
`endif

   // Round-robin scans upward from rr_ptr_q; fixed mode scans from index 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int k = 0; k < NUM_SRC; k++) begin
         int idx;
         idx = mode_q ? int'(rr_ptr_q) + k : k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!win_found && eligible[idx]) begin
            win_found = 1'b1;
            win_idx   = 3'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      irq_d     = irq_q;
      rr_ptr_d  = rr_ptr_q;
      mask_d    = mask_q;
      mode_d    = mode_q;
      ack_d     = capture;
      pending_d = pending_q & ~wr_clr;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               cause_d = {5'd0, win_idx};
               irq_d   = 1'b1;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (CPU_IRQ_ACK) begin
               for (int i = 0; i < NUM_SRC; i++)
                  if (cause_q == 8'(i)) pending_d[i] = 1'b0;
               rr_ptr_d = (cause_q[2:0] == 3'(NUM_SRC - 1)) ? 3'd0 : cause_q[2:0] + 3'd1;
               irq_d    = 1'b0;
               cause_d  = 8'hFF;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // New captures override both software clears and the service clear.
      pending_d = pending_d | capture;
      if (BUS_WE && offset == 8'd0) mask_d = BUS_DATA;
      if (BUS_WE && offset == 8'd3) mode_d = BUS_DATA[0];
   end

   always_comb begin
      rd_sel = 8'h00;
      rd_hit = 1'b0;
      case (offset)
         8'd0: begin rd_sel = mask_q;            rd_hit = 1'b1; end
         8'd1: begin rd_sel = 8'(pending_q);     rd_hit = 1'b1; end
         8'd2: begin rd_sel = cause_q;           rd_hit = 1'b1; end
         8'd3: begin rd_sel = {7'd0, mode_q};    rd_hit = 1'b1; end
         default: ;
      endcase
`ifdef IRQ_HUB_COUNT_EN
      for (int i = 0; i < NUM_SRC; i++) begin
         if (offset == 8'(4 + i)) begin
            rd_sel = cnt_flat[8*i +: 8];
            rd_hit = 1'b1;
         end
      end
`endif
   end

   // Read data is snapshotted on the address edge and driven for the following cycle.
   always_comb begin
      rd_pend_d = rd_hit && !BUS_WE;
      rd_data_d = rd_sel;
      out_d     = rd_data_q;
      drv_d     = rd_pend_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         pending_q <= '0;
         ack_q     <= '0;
         mask_q    <= MASK_RESET;
         cause_q   <= 8'hFF;
         mode_q    <= 1'b0;
         irq_q     <= 1'b0;
         rr_ptr_q  <= 3'd0;
         rd_data_q <= 8'h00;
         out_q     <= 8'h00;
         rd_pend_q <= 1'b0;
         drv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         mask_q    <= mask_d;
         cause_q   <= cause_d;
         mode_q    <= mode_d;
         irq_q     <= irq_d;
         rr_ptr_q  <= rr_ptr_d;
         rd_data_q <= rd_data_d;
         out_q     <= out_d;
         rd_pend_q <= rd_pend_d;
         drv_q     <= drv_d;
      end
   end

   assign BUS_DATA      = drv_q ? out_q : 8'hzz;
   assign SRC_ACK       = ack_q;
   assign CPU_IRQ_RAISE = irq_q;

endmodule

// File: tb/tb_irq_hub.sv
// Bench for irq_hub: per-cycle vector table with a read-data scoreboard, plus hand sequences
// for counter saturation and asynchronous reset during service.
`timescale 1ns/1ps
module tb_irq_hub;
   localparam int         N = 4;
   localparam logic [7:0] B = 8'hE0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   wire  [7:0]   bus_data;
   logic [7:0]   bus_addr = 8'h00;
   logic [7:0]   wdata = 8'h00;
   logic         bus_we = 1'b0;
   logic [N-1:0] src_raise = '0;
   logic [N-1:0] src_ack;
   logic         irq;
   logic         cpu_ack = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   assign bus_data = bus_we ? wdata : 8'hzz;
   always #5 clk = ~clk;

   irq_hub #(.NUM_SRC(N), .BASE_ADDR(B), .MASK_RESET(8'hFF)) dut (
      .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
      .SRC_RAISE(src_raise), .SRC_ACK(src_ack), .CPU_IRQ_RAISE(irq), .CPU_IRQ_ACK(cpu_ack)
   );

   typedef struct {
      string        name;
      logic [N-1:0] raise;
      logic         cack;
      logic         we;
      logic         rd;
      logic [7:0]   addr;
      logic [7:0]   data;      // write data, or expected read data when rd=1
      logic [N-1:0] exp_ack;
      logic         exp_irq;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } rd_exp_t;

   vec_t    tbl[$];
   rd_exp_t sb[$];
   logic    rd_issue = 1'b0;
   logic    rd_s1 = 1'b0;
   logic    rd_s2 = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   function automatic void add(input string nm, input logic [N-1:0] raise, input logic cack,
                               input logic we, input logic rd, input logic [7:0] addr,
                               input logic [7:0] data, input logic [N-1:0] eack, input logic eirq);
      vec_t v;
      v.name = nm; v.raise = raise; v.cack = cack; v.we = we; v.rd = rd;
      v.addr = addr; v.data = data; v.exp_ack = eack; v.exp_irq = eirq;
      tbl.push_back(v);
   endfunction

   // Read results appear on the bus two edges after the address is presented.
   always @(posedge clk) begin
      rd_s1 <= rd_issue;
      rd_s2 <= rd_s1;
   end

   always @(negedge clk) begin
      if (rd_s2) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 8'h01, 8'h00);
         end else begin
            rd_exp_t e;
            e = sb.pop_front();
            chk(e.name, bus_data, e.exp);
            $display("read %-12s data=%h expected=%h", e.name, bus_data, e.exp);
         end
      end
   end

   // Entered at negedge+1: drive one row, then check outputs at the next negedge.
   task automatic apply(input vec_t v);
      rd_exp_t e;
      src_raise = v.raise;
      cpu_ack   = v.cack;
      bus_we    = v.we;
      bus_addr  = (v.we || v.rd) ? v.addr : 8'h00;
      wdata     = v.data;
      rd_issue  = v.rd;
      if (v.rd) begin
         e.name = v.name;
         e.exp  = v.data;
         sb.push_back(e);
      end
      @(negedge clk);
      chk({v.name, "/ack"}, 8'(src_ack), 8'(v.exp_ack));
      chk({v.name, "/irq"}, {7'd0, irq}, {7'd0, v.exp_irq});
      $display("row %-12s ack=%b irq=%b", v.name, src_ack, irq);
      #1;
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) apply(tbl[i]);
      tbl.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst/irq", {7'd0, irq}, 8'h00);
      chk("rst/ack", 8'(src_ack), 8'h00);
      #1 rst = 1'b0;

      // Reset register values
      add("r_mask",  0, 0, 0, 1, B+0, 8'hFF, 0, 0);
      add("r_pend",  0, 0, 0, 1, B+1, 8'h00, 0, 0);
      add("r_cause", 0, 0, 0, 1, B+2, 8'hFF, 0, 0);
      add("r_mode",  0, 0, 0, 1, B+3, 8'h00, 0, 0);
`ifdef IRQ_HUB_COUNT_EN
      add("r_cnt0",  0, 0, 0, 1, B+4, 8'h00, 0, 0);
`endif
      add("r_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("r_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      // Single source 1: capture, raise, ack
      add("a_cap",   4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0);
      add("a_pend",  4'b0000, 0, 0, 1, B+1, 8'h02, 0, 1);
      add("a_cause", 4'b0000, 0, 0, 1, B+2, 8'h01, 0, 1);
      add("a_ack",   4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("a_cause2",4'b0000, 0, 0, 1, B+2, 8'hFF, 0, 0);
      add("a_pend2", 4'b0000, 0, 0, 1, B+1, 8'h00, 0, 0);
      add("a_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("a_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      // Fixed priority, sources 1 and 3 together: serve 1 then 3
      add("b_cap",   4'b1010, 0, 0, 0, 0, 0, 4'b1010, 0);
      add("b_irq1",  4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("b_cause1",4'b0000, 0, 0, 1, B+2, 8'h01, 0, 1);
      add("b_ack1",  4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("b_irq3",  4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("b_cause3",4'b0000, 0, 0, 1, B+2, 8'h03, 0, 1);
      add("b_ack3",  4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("b_pend",  4'b0000, 0, 0, 1, B+1, 8'h00, 0, 0);
      add("b_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("b_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      // Round-robin: serve 1 to leave RR_PTR=2, then pending 1011 -> 3, 0, 1
      add("c_mode",  4'b0000, 0, 1, 0, B+3, 8'h01, 0, 0);
      add("c_cap1",  4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0);
      add("c_irq1",  4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("c_ack1",  4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("c_cap",   4'b1011, 0, 0, 0, 0, 0, 4'b1011, 0);
      add("c_irqa",  4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("c_cause3",4'b0000, 0, 0, 1, B+2, 8'h03, 0, 1);
      add("c_acka",  4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("c_irqb",  4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("c_cause0",4'b0000, 0, 0, 1, B+2, 8'h00, 0, 1);
      add("c_ackb",  4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("c_irqc",  4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("c_cause1",4'b0000, 0, 0, 1, B+2, 8'h01, 0, 1);
      add("c_ackc",  4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("c_pend",  4'b0000, 0, 0, 1, B+1, 8'h00, 0, 0);
      add("c_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("c_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      // Masked source 1 is ignored until unmasked
      add("d_mask",  4'b0000, 0, 1, 0, B+0, 8'hFD, 0, 0);
      add("d_hold1", 4'b0010, 0, 0, 0, 0, 0, 0, 0);
      add("d_hold2", 4'b0010, 0, 0, 0, 0, 0, 0, 0);
      add("d_pend",  4'b0010, 0, 0, 1, B+1, 8'h00, 0, 0);
      add("d_hold3", 4'b0010, 0, 0, 0, 0, 0, 0, 0);
      add("d_hold4", 4'b0010, 0, 0, 0, 0, 0, 0, 0);
      add("d_unmask",4'b0010, 0, 1, 0, B+0, 8'hFF, 0, 0);
      add("d_cap",   4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0);
      add("d_irq",   4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("d_ack",   4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("d_idle",  4'b0000, 0, 0, 0, 0, 0, 0, 0);
      // Capture beats write-1-clear; clearing the served bit does not abort service
      add("e_capclr",4'b0001, 0, 1, 0, B+1, 8'h01, 4'b0001, 0);
      add("e_irq",   4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("e_pend",  4'b0000, 0, 0, 1, B+1, 8'h01, 0, 1);
      add("e_w0",    0, 0, 0, 0, 0, 0, 0, 1);
      add("e_w1",    0, 0, 0, 0, 0, 0, 0, 1);
      add("e_swclr", 4'b0000, 0, 1, 0, B+1, 8'h01, 0, 1);
      add("e_hold",  0, 0, 0, 0, 0, 0, 0, 1);
      add("e_pend2", 4'b0000, 0, 0, 1, B+1, 8'h00, 0, 1);
      add("e_cause", 4'b0000, 0, 0, 1, B+2, 8'h00, 0, 1);
      add("e_w2",    0, 0, 0, 0, 0, 0, 0, 1);
      add("e_w3",    0, 0, 0, 0, 0, 0, 0, 1);
      add("e_ack",   4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("e_cause2",4'b0000, 0, 0, 1, B+2, 8'hFF, 0, 0);
      add("e_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("e_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      // CPU ack while idle is ignored
      add("f_cap",   4'b0100, 0, 0, 0, 0, 0, 4'b0100, 0);
      add("f_idleack",4'b0000, 1, 0, 0, 0, 0, 0, 1);
      add("f_cause", 4'b0000, 0, 0, 1, B+2, 8'h02, 0, 1);
      add("f_hold",  0, 0, 0, 0, 0, 0, 0, 1);
      add("f_ack",   4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("f_pend",  4'b0000, 0, 0, 1, B+1, 8'h00, 0, 0);
      add("f_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("f_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      run_tbl();

`ifdef IRQ_HUB_COUNT_EN
      // Clearing pending[2] every cycle lets the held source re-capture on alternate edges.
      src_raise = 4'b0100;
      bus_we    = 1'b1;
      bus_addr  = B + 8'd1;
      wdata     = 8'h04;
      repeat (600) @(negedge clk);
      #1;
      add("g_stop",  4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("g_sat",   4'b0000, 0, 0, 1, B+6, 8'hFF, 0, 0);
      add("g_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("g_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      add("g_clr",   4'b0000, 0, 1, 0, B+6, 8'h00, 0, 0);
      add("g_zero",  4'b0000, 0, 0, 1, B+6, 8'h00, 0, 0);
      add("g_dr2",   0, 0, 0, 0, 0, 0, 0, 0);
      add("g_dr3",   0, 0, 0, 0, 0, 0, 0, 0);
      add("g_capclr",4'b0100, 0, 1, 0, B+6, 8'h00, 4'b0100, 0);
      add("g_irq",   4'b0000, 0, 0, 0, 0, 0, 0, 1);
      add("g_one",   4'b0000, 0, 0, 1, B+6, 8'h01, 0, 1);
      add("g_ack",   4'b0000, 1, 0, 0, 0, 0, 0, 0);
      add("g_dr4",   0, 0, 0, 0, 0, 0, 0, 0);
      add("g_dr5",   0, 0, 0, 0, 0, 0, 0, 0);
      run_tbl();
`endif

      // Asynchronous reset in the middle of a service
      add("h_cap",   4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0);
      add("h_irq",   4'b0000, 0, 0, 0, 0, 0, 0, 1);
      run_tbl();
      #2 rst = 1'b1;
      #1;
      chk("h_async/irq", {7'd0, irq}, 8'h00);
      chk("h_async/ack", 8'(src_ack), 8'h00);
      $display("async reset irq=%b ack=%b", irq, src_ack);
      @(negedge clk);
      #1 rst = 1'b0;
      add("h_mode",  4'b0000, 0, 0, 1, B+3, 8'h00, 0, 0);
      add("h_pend",  4'b0000, 0, 0, 1, B+1, 8'h00, 0, 0);
      add("h_cause", 4'b0000, 0, 0, 1, B+2, 8'hFF, 0, 0);
      add("h_dr0",   0, 0, 0, 0, 0, 0, 0, 0);
      add("h_dr1",   0, 0, 0, 0, 0, 0, 0, 0);
      run_tbl();

      chk("sb_drain", 8'(sb.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
